nor_reduce_pipe: RTL and testbench

//  Parametrised, pipelined wide NOR/OR reduction built from radix-4 levels, the

---
 rtl/nor_reduce_pkg.sv | 31 +++
 rtl/nor_reduce_level.sv | 47 ++++
 rtl/nor_reduce_pipe.sv | 103 ++++++++++
 tb/tb_nor_reduce_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nor_reduce_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined NOR/OR reducer.
// Level counts and per-level lane counts are derived here so every file agrees on them.
package nor_reduce_pkg;

    localparam int POL_NOR = 1;
    localparam int POL_OR  = 0;

    // Number of radix-4 levels needed to fold WIDTH lanes down to one (never below 1).
    function automatic int clog4(input int width);
        int levels;
        int span;
        levels = 1;
        span   = 4;
        while (span < width) begin
            span   = span * 4;
            levels = levels + 1;
        end
        return levels;
    endfunction

    // Lanes produced by level k: ceil(width / 4^(k+1)).
    function automatic int lanes_at_level(input int width, input int k);
        int div;
        div = 4;
        for (int i = 0; i < k; i++) begin
            div = div * 4;
        end
        return (width + div - 1) / div;
    endfunction

endpackage

// File: rtl/nor_reduce_level.sv
// One registered radix-4 OR level: groups of four inputs are ORed, a partial last
// group is zero-padded, and the optional inversion is folded in before the register.
module nor_reduce_level #(
    parameter int IN_W   = 16,
    parameter bit INVERT = 1'b0
) (
    input  logic                      CLK,
    input  logic                      RN,
    input  logic                      en_i,
    input  logic                      valid_i,
    input  logic [IN_W-1:0]           data_i,
    output logic                      valid_o,
    output logic [(IN_W+3)/4-1:0]     data_o
);

    localparam int OUT_W = (IN_W + 3) / 4;

    logic [4*OUT_W-1:0] padded;
    logic [OUT_W-1:0]   data_d;
    logic [OUT_W-1:0]   data_q;
    logic               valid_q;

    assign padded = (4 * OUT_W)'(data_i);

    always_comb begin
        // NOTE: default every bit first so no path through this block can infer a latch.
        data_d = '0;
        for (int g = 0; g < OUT_W; g++) begin
            data_d[g] = INVERT ^ (|padded[4*g +: 4]);
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments keep every stage sampling the pre-edge value of its predecessor.
        if (!RN) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/nor_reduce_pipe.sv
// Pipelined wide NOR/OR reducer with lane masking, whole-pipe valid/ready stall and a
// saturating hit counter with a sticky flag; used as a zero/flag detector on wide buses.
module nor_reduce_pipe
    import nor_reduce_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int POLARITY = POL_NOR,
    parameter int CNT_W    = 8
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] MASK,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             ZN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    input  logic             CLR,
    output logic [CNT_W-1:0] HIT_CNT,
    output logic             HIT_STICKY
);

    localparam int LEVELS = clog4(WIDTH);

    logic adv;

    // The whole pipe moves as one; bubbles are carried rather than squeezed out.
    assign adv      = ~OUT_VALID | OUT_READY;
    assign IN_READY = adv & RN;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int IN_W  = (k == 0) ? WIDTH : lanes_at_level(WIDTH, k - 1);
        localparam int OUT_W = lanes_at_level(WIDTH, k);
        localparam bit INV   = (k == LEVELS - 1) && (POLARITY == POL_NOR);

        logic [IN_W-1:0]  din;
        logic             vin;
        logic [OUT_W-1:0] dout;
        logic             vout;

        if (k == 0) begin : g_first
            assign din = A & MASK;
            assign vin = IN_VALID & IN_READY;
        end else begin : g_next
            assign din = g_lvl[k-1].dout;
            assign vin = g_lvl[k-1].vout;
        end

        nor_reduce_level #(
            .IN_W   (IN_W),
            .INVERT (INV)
        ) u_level (
            .CLK     (CLK),
            .RN      (RN),
            .en_i    (adv),
            .valid_i (vin),
            .data_i  (din),
            .valid_o (vout),
            .data_o  (dout)
        );
    end

    // Polarity is applied ahead of the last register, so a reset ZN reads 0.
    assign ZN        = g_lvl[LEVELS-1].dout[0];
    assign OUT_VALID = g_lvl[LEVELS-1].vout;

    logic             hit;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             sticky_d;
    logic             sticky_q;

    assign hit = OUT_VALID & OUT_READY & ZN;

    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (CLR) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (hit) begin
            if (~&cnt_q) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign HIT_CNT    = cnt_q;
    assign HIT_STICKY = sticky_q;

endmodule

// File: tb/tb_nor_reduce_pipe.sv
// Scoreboard bench: a directed instance (WIDTH=16, NOR, CNT_W=2) plus a sweep of
// WIDTH x POLARITY instances driven with random lanes, masks and back-pressure.
module tb_nor_reduce_pipe;

    typedef struct {
        logic zn;
        int   cyc;
        bit   exact;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests    = 0;
    int n_fail     = 0;
    int sweep_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sweep_width(input int g);
        case (g / 2)
            0:       return 4;
            1:       return 5;
            2:       return 32;
            default: return 256;
        endcase
    endfunction

    function automatic int exp_levels(input int w);
        case (w)
            4:       return 1;
            5:       return 2;
            16:      return 2;
            32:      return 3;
            default: return 4;
        endcase
    endfunction

    // ---------------- directed instance ----------------
    logic        d_rn, d_iv, d_ir, d_zn, d_ov, d_or, d_clr, d_sticky;
    logic [15:0] d_a, d_m;
    logic [1:0]  d_cnt;
    exp_t        d_q[$];
    int          d_cyc      = 0;
    int          exp_cnt    = 0;
    logic        exp_sticky = 1'b0;
    bit          d_exact    = 1'b1;

    nor_reduce_pipe #(.WIDTH(16), .POLARITY(1), .CNT_W(2)) u_dir (
        .CLK(clk), .RN(d_rn), .A(d_a), .MASK(d_m), .IN_VALID(d_iv), .IN_READY(d_ir),
        .ZN(d_zn), .OUT_VALID(d_ov), .OUT_READY(d_or), .CLR(d_clr),
        .HIT_CNT(d_cnt), .HIT_STICKY(d_sticky)
    );

    // Drive one cycle at the falling edge, then log the handshakes the next rising edge will take.
    task automatic d_step(input logic [15:0] a, input logic [15:0] m, input logic iv,
                          input logic ordy, input logic clr, input logic rn);
        exp_t e;
        @(negedge clk);
        d_a = a; d_m = m; d_iv = iv; d_or = ordy; d_clr = clr; d_rn = rn;
        #1;
        d_cyc++;
        check("dir_cnt", 32'(d_cnt), 32'(exp_cnt));
        check("dir_sticky", 32'(d_sticky), 32'(exp_sticky));
        if (!rn) begin
            check("dir_rst_ir", 32'(d_ir), 0);
            d_q.delete();
            exp_cnt    = 0;
            exp_sticky = 1'b0;
        end else begin
            if (d_ov && ordy) begin
                if (d_q.size() == 0) begin
                    check("dir_spurious_out", 1, 0);
                end else begin
                    e = d_q.pop_front();
                    check("dir_zn", 32'(d_zn), 32'(e.zn));
                    if (e.exact) check("dir_latency", 32'(d_cyc - e.cyc), 2);
                    if (!clr && e.zn) begin
                        if (exp_cnt != 3) exp_cnt++;
                        exp_sticky = 1'b1;
                    end
                end
            end
            if (clr) begin
                exp_cnt    = 0;
                exp_sticky = 1'b0;
            end
            if (iv && d_ir) d_q.push_back('{zn: ~|(a & m), cyc: d_cyc, exact: d_exact});
        end
    endtask

    task automatic d_idle(input int n);
        for (int i = 0; i < n; i++) d_step(16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        logic [15:0] ra;
        d_rn = 1'b0; d_iv = 1'b0; d_or = 1'b0; d_clr = 1'b0; d_a = '0; d_m = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ov", 32'(d_ov), 0);
        check("rst_zn", 32'(d_zn), 0);
        check("rst_cnt", 32'(d_cnt), 0);
        check("rst_sticky", 32'(d_sticky), 0);
        check("rst_ir", 32'(d_ir), 0);

        // All-zero input through NOR: one hit.
        d_step(16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        d_idle(3);
        check("t1_cnt", 32'(d_cnt), 1);
        check("t1_sticky", 32'(d_sticky), 1);

        // Single set lane, unmasked then masked away.
        d_step(16'h0100, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        d_step(16'h0100, 16'hFEFF, 1'b1, 1'b1, 1'b0, 1'b1);
        d_idle(4);

        // Back-to-back stream, then a 5-cycle stall with the head held.
        d_exact = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ra = ($urandom_range(0, 1) == 1) ? 16'h0 : 16'($urandom);
            d_step(ra, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            d_step(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
            check("t3_stall_ov", 32'(d_ov), 1);
            check("t3_stall_ir", 32'(d_ir), 0);
            if (d_q.size() > 0) check("t3_stall_zn", 32'(d_zn), 32'(d_q[0].zn));
            else check("t3_stall_queue", 0, 1);
        end
        d_idle(4);
        check("t3_drain", 32'(d_q.size()), 0);
        d_exact = 1'b1;

        // Saturation at 3, then CLR colliding with a hit.
        d_step(16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) d_step(16'h0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        d_idle(3);
        check("t4_sat_cnt", 32'(d_cnt), 3);
        check("t4_sat_sticky", 32'(d_sticky), 1);
        d_step(16'h0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        d_idle(1);
        d_step(16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        d_idle(1);
        check("t4_clr_hit_cnt", 32'(d_cnt), 0);
        check("t4_clr_hit_sticky", 32'(d_sticky), 0);

        // Reset with two items in flight.
        d_step(16'h0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        d_idle(3);
        check("t5_pre_cnt", 32'(d_cnt), 1);
        d_step(16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        d_step(16'h0100, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        d_step(16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        d_idle(1);
        check("t5_ov", 32'(d_ov), 0);
        check("t5_cnt", 32'(d_cnt), 0);
        check("t5_ir", 32'(d_ir), 1);
        d_idle(2);
        check("t5_flushed", 32'(d_ov), 0);
        d_step(16'h0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        d_idle(3);
        check("t5_post_cnt", 32'(d_cnt), 1);
        check("t5_post_drain", 32'(d_q.size()), 0);

        for (int i = 0; i < 3000 && sweep_done < 8; i++) @(negedge clk);
        check("sweep_done", 32'(sweep_done), 8);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- WIDTH x POLARITY sweep ----------------
    for (genvar g = 0; g < 8; g++) begin : g_sweep
        localparam int W  = sweep_width(g);
        localparam int P  = g % 2;
        localparam int LV = exp_levels(W);

        logic         rn, iv, ir, zn, ov, ordy, clr, sticky;
        logic [W-1:0] a, m;
        logic [7:0]   cnt;
        exp_t         q[$];
        int           cyc = 0;

        nor_reduce_pipe #(.WIDTH(W), .POLARITY(P), .CNT_W(8)) u_dut (
            .CLK(clk), .RN(rn), .A(a), .MASK(m), .IN_VALID(iv), .IN_READY(ir),
            .ZN(zn), .OUT_VALID(ov), .OUT_READY(ordy), .CLR(clr),
            .HIT_CNT(cnt), .HIT_STICKY(sticky)
        );

        initial begin
            logic [255:0] ra, rm;
            logic         e_or;
            exp_t         e;
            rn = 1'b0; iv = 1'b0; ordy = 1'b0; clr = 1'b0; a = '0; m = '0;
            repeat (2) @(negedge clk);
            for (int t = 0; t < 260; t++) begin
                @(negedge clk);
                rn = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    ra[k*32 +: 32] = $urandom;
                    rm[k*32 +: 32] = $urandom;
                end
                case ($urandom_range(0, 4))
                    0: ra = '0;
                    1: rm = '0;
                    2: begin ra = '0; ra[$urandom_range(0, W - 1)] = 1'b1; end
                    3: begin rm = '0; rm[$urandom_range(0, W - 1)] = 1'b1; end
                    default: ;
                endcase
                a    = ra[W-1:0];
                m    = rm[W-1:0];
                iv   = ($urandom_range(0, 3) != 0);
                ordy = 1'b1;
                if (t >= 60 && t < 70) iv = 1'b0;
                if (t >= 70 && t < 220) ordy = ($urandom_range(0, 2) != 0);
                if (t >= 220) iv = 1'b0;
                #1;
                cyc++;
                if (ov && ordy) begin
                    if (q.size() == 0) begin
                        check($sformatf("w%0d_p%0d_spurious_out", W, P), 1, 0);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("w%0d_p%0d_zn", W, P), 32'(zn), 32'(e.zn));
                        if (e.exact)
                            check($sformatf("w%0d_p%0d_latency", W, P), 32'(cyc - e.cyc), 32'(LV));
                    end
                end
                if (iv && ir) begin
                    e_or = |(a & m);
                    q.push_back('{zn: (P == 1) ? ~e_or : e_or, cyc: cyc, exact: (t < 60)});
                end
            end
            check($sformatf("w%0d_p%0d_drain", W, P), 32'(q.size()), 0);
            sweep_done++;
        end
    end

endmodule
